texture_loader: RTL and testbench
=================================

TEXTURE_LOADER -- requirements
Module: texture_loader

Interface
REQ-001 The module SHALL have parameter TILE_BITS, default 8, giving the tile-index width (256 tiles).
REQ-002 The module SHALL have parameter OFF_BITS, default 4, giving the per-axis pixel-offset width (16x16 tiles).
REQ-003 The module SHALL have port clk  input  1  single system clock; all state SHALL be updated on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port in_data  input  8  byte stream from the host link.
REQ-006 The module SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-007 The module SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 The module SHALL have port abort  input  1  synchronous cancel of the tile upload in progress.
REQ-009 The module SHALL have port we  output  1  texture RAM write enable.
REQ-010 The module SHALL have port waddr  output  TILE_BITS+2*OFF_BITS (16)  write address {tile, off_y, off_x}.
REQ-011 The module SHALL have port wdata  output  12  RGB444 write word.
REQ-012 The module SHALL have port busy  output  1  a tile upload is in progress.
REQ-013 The module SHALL have port done  output  1  one-cycle pulse when a tile upload completes.

Function
REQ-014 A byte SHALL be consumed only on a cycle where in_valid and in_ready are both high.
REQ-015 in_ready SHALL equal (state != DONE) && !abort, with no other combinational dependency.
REQ-016 The FSM SHALL have states IDLE, HDR_OK, DATA, and DONE.
REQ-017 In IDLE, a consumed byte SHALL latch its low TILE_BITS as the tile index, clear the pixel counter and byte phase, and move the FSM to DATA.
REQ-018 In DATA, bytes SHALL cycle through phases 0, 1, 2 to pack two pixels into three bytes: b0, b1, b2.
REQ-019 Pixel 0 SHALL be {b0, b1[7:4]}, and pixel 1 SHALL be {b1[3:0], b2}.
REQ-020 On consuming phase 1, the module SHALL issue a write of pixel 0; on consuming phase 2, it SHALL issue a write of pixel 1.
REQ-021 we, waddr, and wdata SHALL be registered and asserted the cycle after the consuming handshake, giving a latency of 1.
REQ-022 we SHALL be high for exactly one cycle per pixel.
REQ-023 waddr SHALL be {tile, pix_cnt}, where pix_cnt (2*OFF_BITS wide) starts at 0 and increments after each write.
REQ-024 Pixels SHALL be written in raster order, with off_x incrementing fastest.
REQ-025 A tile SHALL comprise exactly 2^(2*OFF_BITS) pixels, which is 384 data bytes at default parameters.
REQ-026 After the write of the last pixel (pix_cnt = 255) is issued, the FSM SHALL enter DONE for exactly one cycle; during DONE, done=1 and in_ready=0, and the FSM SHALL then return to IDLE.
REQ-027 pix_cnt SHALL NOT be used after it wraps past 255; the DONE transition SHALL occur before it wraps.
REQ-028 busy SHALL be 1 in DATA and DONE, and 0 in IDLE.
REQ-029 Gaps in in_valid SHALL stall progress without affecting the phase or the count.
REQ-030 Asserting abort in any state SHALL return the FSM to IDLE on the next edge, discard the partial pixel, leave done low, and issue no further writes.
REQ-031 A write already registered on the abort cycle SHALL still complete.
REQ-032 If abort and in_valid are both high, abort SHALL win and the byte SHALL NOT be consumed.
REQ-033 A header byte whose upper bits exceed TILE_BITS SHALL be truncated silently.

Reset
REQ-034 While rst is high, the FSM SHALL be in IDLE, and the outputs SHALL be in_ready=1, we=0, waddr=0, wdata=0, busy=0, done=0; tile, pix_cnt, phase, and the byte latch SHALL all be 0.
REQ-035 A reset asserted mid-tile SHALL abandon the tile without a done pulse; the next consumed byte after release SHALL be treated as a header.

Structure
REQ-036 TILE_BITS, OFF_BITS, the derived address width, and the FSM state enumeration SHALL live in the shared texture package that also defines the texture ROM/RAM address mapping.
REQ-037 The 3-byte-to-2-pixel unpacker SHALL be a sub-module named rgb444_unpacker, containing the phase counter, the byte latch, and the pixel output with a valid strobe.
REQ-038 The FSM, counters, and write-port registers SHALL remain in texture_loader.

Verification
REQ-039 Scenario: send header 0x05, then bytes 0xAB,0xCD,0xEF -> we pulses twice; the writes SHALL be addr 0x0500 data 0xABC, then addr 0x0501 data 0xDEF.
REQ-040 Scenario: full tile 0xFF with 384 bytes of 0x12,0x34,0x56 -> 256 writes to addrs 0xFF00..0xFFFF alternating data 0x123/0x456, one done pulse on the cycle after the final we, and in_ready low for exactly that cycle.
REQ-041 Scenario: randomly deasserted in_valid during a tile -> write sequence identical to the back-to-back case, with only the timing stretched.
REQ-042 Scenario: abort after header 0x03 plus 100 bytes -> no done pulse and no further we; a following header 0x04 plus 384 bytes SHALL write 0x0400..0x04FF correctly.
REQ-043 Scenario: rst asserted asynchronously mid-phase 1 -> outputs reach reset values immediately; after release, the byte 0x07 SHALL be taken as a header.
REQ-044 Scenario: abort and in_valid both high on the same cycle -> in_ready=0 and the byte is not consumed; the next byte SHALL be treated as a header.

Source files
------------

// File: rtl/texture_loader_pkg.sv
// Shared texture definitions: tile geometry, address mapping, loader FSM states.
package texture_loader_pkg;

  localparam int TEX_TILE_BITS   = 8;
  localparam int TEX_OFF_BITS    = 4;
  localparam int TEX_PIX_BITS    = 2 * TEX_OFF_BITS;
  localparam int TEX_ADDR_BITS   = TEX_TILE_BITS + TEX_PIX_BITS;
  localparam int TEX_RGB_BITS    = 12;
  localparam int TEX_TILE_PIXELS = 1 << TEX_PIX_BITS;
  localparam int TEX_TILE_BYTES  = (TEX_TILE_PIXELS * 3) / 2;

  // Texture ROM/RAM address layout, most significant field first.
  typedef struct packed {
    logic [TEX_TILE_BITS-1:0] tile;
    logic [TEX_OFF_BITS-1:0]  off_y;
    logic [TEX_OFF_BITS-1:0]  off_x;
  } tex_addr_t;

  // Loader FSM. HDR_OK is reserved; the header byte moves IDLE straight to DATA.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR_OK = 2'd1,
    DATA   = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  // Flat texture address for a texel of a tile.
  function automatic logic [TEX_ADDR_BITS-1:0] tex_addr(
    input logic [TEX_TILE_BITS-1:0] tile,
    input logic [TEX_OFF_BITS-1:0]  off_y,
    input logic [TEX_OFF_BITS-1:0]  off_x
  );
    tex_addr_t a;
    a.tile  = tile;
    a.off_y = off_y;
    a.off_x = off_x;
    return a;
  endfunction

endpackage

// File: rtl/texture_loader_unpacker.sv
// Packs a byte stream into RGB444 pixels: three bytes b0,b1,b2 give
// pixel 0 = {b0, b1[7:4]} and pixel 1 = {b1[3:0], b2}.
module rgb444_unpacker
  import texture_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [TEX_RGB_BITS-1:0] pix,
  output logic                    pix_valid
);

  logic [1:0] phase;
  logic [7:0] byte_latch;

  // Phase counter and previous-byte latch; clear discards any partial pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 2'd0;
      byte_latch <= 8'h00;
    end else if (clear) begin
      phase      <= 2'd0;
      byte_latch <= 8'h00;
    end else if (byte_valid) begin
      byte_latch <= byte_in;
      phase      <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
    end
  end

  // A pixel completes on the bytes consumed in phases 1 and 2.
  always_comb begin
    pix       = '0;
    pix_valid = 1'b0;
    if (byte_valid && !clear) begin
      case (phase)
        2'd1: begin
          pix       = {byte_latch, byte_in[7:4]};
          pix_valid = 1'b1;
        end
        2'd2: begin
          pix       = {byte_latch[3:0], byte_in};
          pix_valid = 1'b1;
        end
        default: begin
          pix       = '0;
          pix_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/texture_loader.sv
// Tile upload engine: header byte selects a tile, then 3*2^(2*OFF_BITS-1)
// data bytes are unpacked into RGB444 texels and written in raster order.
//
// state  | meaning
// IDLE   | waiting for a header byte (tile index)
// HDR_OK | reserved, never entered
// DATA   | unpacking data bytes, one write per completed pixel
// DONE   | one-cycle completion pulse, no byte accepted
module texture_loader
  import texture_loader_pkg::*;
#(
  parameter int TILE_BITS = TEX_TILE_BITS,
  parameter int OFF_BITS  = TEX_OFF_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            abort,
  output logic                            we,
  output logic [TILE_BITS+2*OFF_BITS-1:0] waddr,
  output logic [TEX_RGB_BITS-1:0]         wdata,
  output logic                            busy,
  output logic                            done
);

  localparam int PIX_BITS = 2 * OFF_BITS;

  loader_state_t        state, state_next;
  logic [TILE_BITS-1:0] tile;
  logic [PIX_BITS-1:0]  pix_cnt;
  logic                 wr_last;
  logic                 consume;
  logic                 feed;
  logic                 unpack_clear;
  logic [TEX_RGB_BITS-1:0] pix;
  logic                 pix_valid;

  assign in_ready = (state != DONE) && !abort;
  assign consume  = in_valid && in_ready;
  assign busy     = (state == DATA) || (state == DONE);
  assign done     = (state == DONE);

  // wr_last marks the cycle the final write is on the port; the tile is
  // complete then, so a byte offered in that cycle is not unpacked.
  assign feed         = consume && (state == DATA) && !wr_last;
  assign unpack_clear = abort || (state != DATA);

  rgb444_unpacker u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .clear      (unpack_clear),
    .byte_in    (in_data),
    .byte_valid (feed),
    .pix        (pix),
    .pix_valid  (pix_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (consume) state_next = DATA;
      DATA:    if (wr_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Tile index, pixel counter and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile    <= '0;
      pix_cnt <= '0;
      wr_last <= 1'b0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      we      <= pix_valid;
      wr_last <= pix_valid && (pix_cnt == {PIX_BITS{1'b1}});
      if (state == IDLE && consume) begin
        tile    <= TILE_BITS'(in_data);
        pix_cnt <= '0;
      end
      if (pix_valid) begin
        waddr   <= {tile, pix_cnt};
        wdata   <= pix;
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_texture_loader.sv
`timescale 1ns/1ps
module tb_texture_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [11:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        we;
  logic [15:0] waddr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;

  int  vectors = 0;
  int  miscompares = 0;
  int  done_seen = 0;
  wr_t sb[$];

  texture_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Write monitor: every we pulse is checked against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (we) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", waddr, wdata);
      end else begin
        e = sb.pop_front();
        if (waddr !== e.a || wdata !== e.d) begin
          miscompares++;
          $display("FAIL write: got addr %h data %h, required addr %h data %h", waddr, wdata, e.a, e.d);
        end
      end
    end
    if (done) done_seen++;
  end

  task automatic push(input logic [15:0] a, input logic [11:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b, required 0", busy);
    end
  endtask

  task automatic check_sb_empty(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d writes missing, required 0", name, sb.size());
    end
  endtask

  task automatic send_tile(input logic [7:0] t, input bit rnd, input bit gaps);
    logic [7:0] b0, b1, b2, p;
    int d0;
    d0 = done_seen;
    send_byte(t);
    for (int k = 0; k < 128; k++) begin
      b0 = rnd ? 8'($urandom) : 8'h12;
      b1 = rnd ? 8'($urandom) : 8'h34;
      b2 = rnd ? 8'($urandom) : 8'h56;
      p  = 8'(2 * k);
      push({t, p}, {b0, b1[7:4]});
      p  = 8'(2 * k + 1);
      push({t, p}, {b1[3:0], b2});
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(b0);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(b1);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(b2);
    end
    vectors++;
    if (we !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL last_write_cycle: we/done/in_ready %b%b%b, required 101", we, done, in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (we !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done_cycle: we/done/in_ready/busy %b%b%b%b, required 0101", we, done, in_ready, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_done: done/in_ready/busy %b%b%b, required 010", done, in_ready, busy);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (done_seen != d0 + 1) begin
      miscompares++;
      $display("FAIL done_count: got %0d pulses, required 1", done_seen - d0);
    end
    check_sb_empty("tile_writes");
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, we, waddr, wdata, busy, done} !== {1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy %b we %b addr %h data %h busy %b done %b, required 1 0 0000 000 0 0",
               in_ready, we, waddr, wdata, busy, done);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: busy %b in_ready %b, required 0 1", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_seen;
    push(16'h0500, 12'hABC);
    push(16'h0501, 12'hDEF);
    send_byte(8'h05);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    repeat (3) @(negedge clk);
    check_sb_empty("basic_writes");
    vectors++;
    if (busy !== 1'b1 || done_seen != d0) begin
      miscompares++;
      $display("FAIL basic_state: busy %b dones %0d, required 1 0", busy, done_seen - d0);
    end
    do_abort();
  endtask

  task automatic test_abort();
    int d0;
    logic [7:0] b [3];
    logic [7:0] p;
    d0 = done_seen;
    send_byte(8'h03);
    for (int i = 0; i < 100; i++) begin
      b[i % 3] = 8'($urandom);
      if (i % 3 == 1) begin
        p = 8'((i / 3) * 2);
        push({8'h03, p}, {b[0], b[1][7:4]});
      end
      if (i % 3 == 2) begin
        p = 8'((i / 3) * 2 + 1);
        push({8'h03, p}, {b[1][3:0], b[2]});
      end
      send_byte(b[i % 3]);
    end
    do_abort();
    repeat (5) @(negedge clk);
    check_sb_empty("abort_partial");
    vectors++;
    if (done_seen != d0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_done: dones %0d busy %b, required 0 0", done_seen - d0, busy);
    end
    send_tile(8'h04, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    send_byte(8'h09);
    send_byte(8'h11);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({in_ready, we, waddr, wdata, busy, done} !== {1'b1, 1'b0, 16'h0, 12'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: rdy %b we %b addr %h data %h busy %b done %b, required 1 0 0000 000 0 0",
               in_ready, we, waddr, wdata, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    push(16'h0700, 12'h112);
    push(16'h0701, 12'h233);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (3) @(negedge clk);
    check_sb_empty("post_reset_header");
    do_abort();
  endtask

  task automatic test_abort_collision();
    @(negedge clk);
    in_data  = 8'h55;
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_ready: got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_consumed: busy %b, required 0", busy);
    end
    push(16'h0A00, 12'h112);
    push(16'h0A01, 12'h233);
    send_byte(8'h0A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (3) @(negedge clk);
    check_sb_empty("collision_header");
    do_abort();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    abort    = 1'b0;
    test_reset();
    test_basic();
    send_tile(8'hFF, 1'b0, 1'b0);
    send_tile(8'hFF, 1'b0, 1'b1);
    send_tile(8'h21, 1'b1, 1'b1);
    test_abort();
    test_async_reset();
    test_abort_collision();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
